// File: rtl/anton_neopixel_stream_sequencer_pkg.sv
// rtl/anton_neopixel_stream_sequencer_pkg.sv - shared encodings and timing defaults for the neopixel sequencer
//
// Purpose: sequencer state encodings, default WS2812 timing constants and
// a small helper used to size the shared phase counter.

package anton_neopixel_stream_sequencer_pkg;

  localparam int BUFFER_END_DEFAULT   = 255;
  localparam int T0H_DEFAULT          = 7;
  localparam int T1H_DEFAULT          = 14;
  localparam int TBIT_DEFAULT         = 25;
  localparam int RESET_CYCLES_DEFAULT = 1000;
  localparam int INIT_CYCLES_DEFAULT  = 256;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_BIT   = 3'd2,
    ST_LATCH = 3'd3,
    ST_INIT  = 3'd4
  } seq_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/anton_neopixel_bit_encoder.sv
// rtl/anton_neopixel_bit_encoder.sv - one WS2812 bit waveform generator
//
// Purpose: turns one data bit plus a start strobe into the TBIT-cycle
// high/low pattern. The cycle in which start is high is waveform cycle 0,
// so a new start in the cycle after done gives back-to-back bits.
// Ports:
//   clk, resetn  clock, asynchronous active-low reset
//   start        begin a bit this cycle (bit_in sampled now)
//   bit_in       bit value to encode
//   abort        drop any bit in flight
//   level        combinational line level for the current cycle
//   done         high in the last cycle of the bit

module anton_neopixel_bit_encoder #(
  parameter int T0H  = 7,
  parameter int T1H  = 14,
  parameter int TBIT = 25
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic bit_in,
  input  logic abort,
  output logic level,
  output logic done
);

  localparam int CW = $clog2(TBIT);
  localparam logic [CW-1:0] LAST = CW'(TBIT - 1);

  logic          busy_q, busy_d;
  logic          bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          act;
  logic          eff_bit;
  logic [CW-1:0] eff_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q <= 1'b0;
      bit_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      bit_q  <= bit_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    // On the start cycle the registered copy is not loaded yet, so use the inputs.
    act     = start | busy_q;
    eff_cnt = start ? '0 : cnt_q;
    eff_bit = start ? bit_in : bit_q;
    level   = act && (eff_bit ? (eff_cnt < CW'(T1H)) : (eff_cnt < CW'(T0H)));
    done    = act && (eff_cnt == LAST);

    busy_d = busy_q;
    bit_d  = bit_q;
    cnt_d  = cnt_q;
    if (abort) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start) begin
      busy_d = 1'b1;
      bit_d  = bit_in;
      cnt_d  = CW'(1);
    end else if (busy_q) begin
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/anton_neopixel_stream_sequencer.sv
// rtl/anton_neopixel_stream_sequencer.sv - frame buffer reader and WS2812 serialiser
//
// Purpose: walks the pixel buffer from index 0 to the frame end, prefetching
// each next byte while the current one shifts out, then holds the line low
// for the latch time. A slow-init request overrides everything.
// Ports:
//   clk, resetn       clock, asynchronous active-low reset
//   pixelIxComb       combinational buffer read address (registered in the RAM)
//   pixelByte         buffer data, one clock after the address
//   regMax            frame end when regCtrlLimit=1 (clamped to BUFFER_END)
//   regCtrlLimit      use regMax as frame end
//   regCtrlRun        start a frame from IDLE
//   regCtrl32bit      4-byte slots, byte index[1:0]==3 skipped
//   initSlow          slow-init request level
//   initSlowDone      pulse in the last INIT cycle
//   streamSyncOf      pulse in the last LATCH cycle
//   state             1 while in LOAD, BIT or LATCH
//   neoData           registered serial data line

module anton_neopixel_stream_sequencer
  import anton_neopixel_stream_sequencer_pkg::*;
#(
  parameter int BUFFER_END   = BUFFER_END_DEFAULT,
  parameter int T0H          = T0H_DEFAULT,
  parameter int T1H          = T1H_DEFAULT,
  parameter int TBIT         = TBIT_DEFAULT,
  parameter int RESET_CYCLES = RESET_CYCLES_DEFAULT,
  parameter int INIT_CYCLES  = INIT_CYCLES_DEFAULT,
  localparam int BUFFER_BITS = $clog2(BUFFER_END + 1)
) (
  input  logic                   clk,
  input  logic                   resetn,
  output logic [BUFFER_BITS-1:0] pixelIxComb,
  input  logic [7:0]             pixelByte,
  input  logic [12:0]            regMax,
  input  logic                   regCtrlLimit,
  input  logic                   regCtrlRun,
  input  logic                   regCtrl32bit,
  input  logic                   initSlow,
  output logic                   initSlowDone,
  output logic                   streamSyncOf,
  output logic                   state,
  output logic                   neoData
);

  localparam int BB = BUFFER_BITS;
  localparam int CW = $clog2(max3(TBIT, RESET_CYCLES, INIT_CYCLES));
  localparam logic [CW-1:0] RLAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] ILAST = CW'(INIT_CYCLES - 1);

  seq_state_e    fsm_q, fsm_d;
  logic [BB-1:0] ix_q, ix_d;
  logic [BB-1:0] end_ix_q, end_ix_d;
  logic          w32_q, w32_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    hold_q, hold_d;
  logic          first_q, first_d;
  logic          bit_start_q, bit_start_d;
  logic          neo_q, neo_d;
  logic          sync_q, sync_d;
  logic          done_q, done_d;
  logic          state_q, state_d;

  logic [BB-1:0] end_ix_sel;
  logic [BB:0]   next_ix;
  logic [BB:0]   nxt1;
  logic          last_byte;
  logic          abort;
  logic [7:0]    cur_byte;
  logic [2:0]    bit_sel;
  logic          enc_start;
  logic          enc_level;
  logic          enc_done;

  anton_neopixel_bit_encoder #(
    .T0H  (T0H),
    .T1H  (T1H),
    .TBIT (TBIT)
  ) u_enc (
    .clk    (clk),
    .resetn (resetn),
    .start  (enc_start),
    .bit_in (cur_byte[bit_sel]),
    .abort  (abort),
    .level  (enc_level),
    .done   (enc_done)
  );

  // State register (and all datapath flops)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fsm_q       <= ST_IDLE;
      ix_q        <= '0;
      end_ix_q    <= '0;
      w32_q       <= 1'b0;
      bit_cnt_q   <= '0;
      cyc_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      first_q     <= 1'b0;
      bit_start_q <= 1'b0;
      neo_q       <= 1'b0;
      sync_q      <= 1'b0;
      done_q      <= 1'b0;
      state_q     <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      ix_q        <= ix_d;
      end_ix_q    <= end_ix_d;
      w32_q       <= w32_d;
      bit_cnt_q   <= bit_cnt_d;
      cyc_q       <= cyc_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      first_q     <= first_d;
      bit_start_q <= bit_start_d;
      neo_q       <= neo_d;
      sync_q      <= sync_d;
      done_q      <= done_d;
      state_q     <= state_d;
    end
  end

  // Frame-end selection, index advance and current bit source
  always_comb begin
    if (regCtrlLimit && (int'(regMax) < BUFFER_END)) begin
      end_ix_sel = BB'(regMax);
    end else begin
      end_ix_sel = BB'(BUFFER_END);
    end

    // One bit wider than the index so the step past the last byte never wraps.
    nxt1 = {1'b0, ix_q} + (BB+1)'(1);
    if (w32_q && (nxt1[1:0] == 2'b11)) begin
      next_ix = {1'b0, ix_q} + (BB+1)'(2);
    end else begin
      next_ix = nxt1;
    end
    last_byte = next_ix > {1'b0, end_ix_q};

    abort = initSlow && ((fsm_q == ST_LOAD) || (fsm_q == ST_BIT) || (fsm_q == ST_LATCH));

    // The first byte of a frame is used straight off the RAM port in its first cycle.
    cur_byte  = first_q ? pixelByte : shift_q;
    bit_sel   = 3'd7 - bit_cnt_q;
    enc_start = (fsm_q == ST_BIT) && bit_start_q && !abort;
  end

  // Next-state logic
  always_comb begin
    fsm_d       = fsm_q;
    ix_d        = ix_q;
    end_ix_d    = end_ix_q;
    w32_d       = w32_q;
    bit_cnt_d   = bit_cnt_q;
    cyc_d       = cyc_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    first_d     = first_q;
    bit_start_d = bit_start_q;

    case (fsm_q)
      ST_IDLE: begin
        if (initSlow) begin
          fsm_d = ST_INIT;
          cyc_d = '0;
        end else if (regCtrlRun) begin
          fsm_d    = ST_LOAD;
          ix_d     = '0;
          end_ix_d = end_ix_sel;
          w32_d    = regCtrl32bit;
        end
      end
      ST_LOAD: begin
        fsm_d       = ST_BIT;
        bit_cnt_d   = '0;
        first_d     = 1'b1;
        bit_start_d = 1'b1;
      end
      ST_BIT: begin
        bit_start_d = 1'b0;
        if (first_q) begin
          shift_d = pixelByte;
          first_d = 1'b0;
        end
        // The prefetch address is presented for all of bit 0; from its second
        // cycle on the RAM returns the next byte.
        if ((bit_cnt_q == 3'd0) && !bit_start_q) begin
          hold_d = pixelByte;
        end
        if (enc_done) begin
          if (bit_cnt_q == 3'd7) begin
            if (last_byte) begin
              fsm_d = ST_LATCH;
              cyc_d = '0;
            end else begin
              ix_d        = next_ix[BB-1:0];
              shift_d     = hold_q;
              bit_cnt_d   = '0;
              bit_start_d = 1'b1;
            end
          end else begin
            bit_cnt_d   = bit_cnt_q + 3'd1;
            bit_start_d = 1'b1;
          end
        end
      end
      ST_LATCH: begin
        if (cyc_q == RLAST) begin
          fsm_d = ST_IDLE;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      ST_INIT: begin
        if (cyc_q == ILAST) begin
          fsm_d = ST_IDLE;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: begin
        fsm_d = ST_IDLE;
      end
    endcase

    if (abort) begin
      fsm_d       = ST_INIT;
      cyc_d       = '0;
      first_d     = 1'b0;
      bit_start_d = 1'b0;
    end
  end

  // Output logic: registered outputs are computed from the next state so the
  // pulses land inside the last LATCH/INIT cycle itself.
  always_comb begin
    neo_d   = (fsm_q == ST_BIT) && !abort && enc_level;
    state_d = (fsm_d == ST_LOAD) || (fsm_d == ST_BIT) || (fsm_d == ST_LATCH);
    sync_d  = (fsm_d == ST_LATCH) && (cyc_d == RLAST);
    done_d  = (fsm_d == ST_INIT) && (cyc_d == ILAST);

    case (fsm_q)
      ST_LOAD: pixelIxComb = ix_q;
      ST_BIT:  pixelIxComb = (bit_cnt_q == 3'd0) ? next_ix[BB-1:0] : ix_q;
      default: pixelIxComb = '0;
    endcase
  end

  assign neoData      = neo_q;
  assign state        = state_q;
  assign streamSyncOf = sync_q;
  assign initSlowDone = done_q;

endmodule

// File: tb/tb_anton_neopixel_stream_sequencer.sv
// tb/tb_anton_neopixel_stream_sequencer.sv - scoreboard bench for the neopixel sequencer

module tb_anton_neopixel_stream_sequencer;

  localparam int BEND = 15;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  pixelIxComb;
  logic [7:0]  pixelByte;
  logic [12:0] regMax;
  logic        regCtrlLimit, regCtrlRun, regCtrl32bit, initSlow;
  logic        initSlowDone, streamSyncOf, state, neoData;

  logic [7:0]  mem [0:15];

  always #5 clk = ~clk;

  always @(posedge clk) pixelByte <= mem[pixelIxComb];

  anton_neopixel_stream_sequencer #(
    .BUFFER_END (BEND)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .pixelIxComb  (pixelIxComb),
    .pixelByte    (pixelByte),
    .regMax       (regMax),
    .regCtrlLimit (regCtrlLimit),
    .regCtrlRun   (regCtrlRun),
    .regCtrl32bit (regCtrl32bit),
    .initSlow     (initSlow),
    .initSlowDone (initSlowDone),
    .streamSyncOf (streamSyncOf),
    .state        (state),
    .neoData      (neoData)
  );

  int checks = 0;
  int errors = 0;

  // Event codes: 0/1 decoded bit, 2 streamSyncOf, 3 initSlowDone, 4 truncated pulse
  int exp_q[$];
  int len_q[$];

  bit mon_en  = 1'b0;
  bit forbid3 = 1'b0;
  int seen3   = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pop_chk(input string name, input int got);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got event %0d, expected no event", name, got);
    end else begin
      chk(name, got, exp_q.pop_front());
    end
  endtask

  // Monitor
  int hi_len = 0, st_len = 0, last_rise = 0, cyc = 0;
  bit rise_ok = 1'b0, prev_neo = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!mon_en) begin
      hi_len = 0; st_len = 0; rise_ok = 1'b0; prev_neo = 1'b0;
    end else begin
      if (neoData && !prev_neo) begin
        if (rise_ok) chk("rise_spacing", cyc - last_rise, 25);
        last_rise = cyc;
        rise_ok   = 1'b1;
      end
      if (neoData) begin
        hi_len++;
      end else if (hi_len > 0) begin
        pop_chk("bit_event", (hi_len == 14) ? 1 : (hi_len == 7) ? 0 : 4);
        hi_len = 0;
      end
      prev_neo = neoData;
      if (!state) rise_ok = 1'b0;
      if (state) begin
        st_len++;
      end else if (st_len > 0) begin
        if (len_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL state_len: got %0d, expected no busy period", st_len);
        end else begin
          chk("state_len", st_len, len_q.pop_front());
        end
        st_len = 0;
      end
      if (streamSyncOf) pop_chk("sync_event", 2);
      if (initSlowDone) pop_chk("initdone_event", 3);
      if (forbid3 && state && (pixelIxComb == 4'd3)) seen3++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input bit lim, input int rmax, input bit w32);
    int e;
    int n;
    e = lim ? ((rmax < BEND) ? rmax : BEND) : BEND;
    n = 0;
    for (int i = 0; i <= e; i++) begin
      if (w32 && ((i % 4) == 3)) continue;
      n++;
      for (int b = 7; b >= 0; b--) exp_q.push_back(int'(mem[i][b]));
    end
    exp_q.push_back(2);
    len_q.push_back(1 + n * 200 + 1000);
  endtask

  task automatic wait_sync(input string name);
    int k;
    k = 0;
    while (!streamSyncOf && k < 8000) begin
      tick();
      k++;
    end
    chk(name, int'(streamSyncOf), 1);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || len_q.size() != 0) && k < 3000) begin
      tick();
      k++;
    end
    chk({name, "_events_left"}, exp_q.size(), 0);
    chk({name, "_lens_left"}, len_q.size(), 0);
    exp_q.delete();
    len_q.delete();
  endtask

  // Frame settings are scrambled after the start to show they are latched.
  task automatic run_frame(input string name, input bit lim, input int rmax, input bit w32);
    regCtrlLimit = lim;
    regMax       = 13'(rmax);
    regCtrl32bit = w32;
    push_frame(lim, rmax, w32);
    regCtrlRun = 1'b1;
    tick();
    regCtrlRun   = 1'b0;
    regMax       = 13'd0;
    regCtrlLimit = ~lim;
    regCtrl32bit = ~w32;
    wait_sync({name, "_sync"});
    drain(name);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int k;
    int busy_seen;
    resetn = 1'b0; regMax = '0; regCtrlLimit = 1'b0; regCtrlRun = 1'b0;
    regCtrl32bit = 1'b0; initSlow = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_neoData", neoData, 0);
    chk("rst_state", state, 0);
    chk("rst_pixelIx", pixelIxComb, 0);
    chk("rst_sync", streamSyncOf, 0);
    chk("rst_initdone", initSlowDone, 0);
    resetn = 1'b1;
    tick();
    mon_en = 1'b1;

    // Full buffer, single set MSB in byte 0
    mem[0] = 8'h80;
    run_frame("full_80", 1'b0, 0, 1'b0);

    // Limit=1, regMax=2, 32-bit slots
    mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'hF0; mem[3] = 8'hFF;
    seen3 = 0; forbid3 = 1'b1;
    run_frame("lim2_32b", 1'b1, 2, 1'b1);
    forbid3 = 1'b0;
    chk("lim2_addr3_never", seen3, 0);

    // regMax above BUFFER_END clamps
    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 17);
    run_frame("clamp", 1'b1, 4095, 1'b1 ^ 1'b1);

    // Whole buffer in 32-bit mode: every index[1:0]==3 skipped
    seen3 = 0; forbid3 = 1'b1;
    run_frame("full_32b", 1'b0, 0, 1'b1);
    forbid3 = 1'b0;
    chk("full32_addr3_never", seen3, 0);

    // Degenerate single-byte frame
    mem[0] = 8'h69;
    run_frame("one_byte", 1'b1, 0, 1'b0);

    // Run held high: two frames back to back
    mem[0] = 8'hC3; mem[1] = 8'h0F;
    regCtrlLimit = 1'b1; regMax = 13'd1; regCtrl32bit = 1'b0;
    push_frame(1'b1, 1, 1'b0);
    push_frame(1'b1, 1, 1'b0);
    regCtrlRun = 1'b1;
    tick();
    wait_sync("loop_sync1");
    tick();
    chk("loop_gap_idle", state, 0);
    tick();
    chk("loop_restart", state, 1);
    regCtrlRun = 1'b0;
    wait_sync("loop_sync2");
    drain("loop");

    // initSlow during bit 3 of byte 1 (high phase of a 1 bit)
    mem[0] = 8'h5A; mem[1] = 8'hB0;
    regCtrlLimit = 1'b0; regCtrl32bit = 1'b0;
    for (int b = 7; b >= 0; b--) exp_q.push_back(int'(mem[0][b]));
    exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
    exp_q.push_back(4);
    exp_q.push_back(3);
    len_q.push_back(280);
    regCtrlRun = 1'b1;
    tick();
    regCtrlRun = 1'b0;
    repeat (279) tick();
    initSlow = 1'b1;
    tick();
    initSlow = 1'b0;
    chk("abort_neo_low", neoData, 0);
    chk("abort_state_low", state, 0);
    k = 0;
    while (!initSlowDone && k < 1000) begin
      tick();
      k++;
    end
    chk("abort_init_delay", k, 255);
    tick();
    chk("abort_back_idle", state, 0);
    drain("abort");

    // Asynchronous reset mid-BIT
    mon_en = 1'b0;
    regCtrlLimit = 1'b0; regCtrl32bit = 1'b0;
    regCtrlRun = 1'b1;
    tick();
    regCtrlRun = 1'b0;
    repeat (100) tick();
    chk("pre_reset_busy", state, 1);
    #3;
    resetn = 1'b0;
    #1;
    chk("async_rst_neo", neoData, 0);
    chk("async_rst_state", state, 0);
    chk("async_rst_pixelIx", pixelIxComb, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    busy_seen = 0;
    repeat (50) begin
      tick();
      if (state) busy_seen++;
    end
    chk("no_resume_after_reset", busy_seen, 0);
    exp_q.delete();
    len_q.delete();
    mon_en = 1'b1;
    tick();

    // New Run after reset
    mem[0] = 8'h96;
    run_frame("post_reset", 1'b1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
